// File: rtl/ysyx_23060203_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; a zero divisor skips straight to the result.
module ysyx_23060203_div_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic        in_sign,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_quot,
  output logic [31:0] out_rem
);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_sh_q;   // dividend magnitude, consumed MSB first
  logic [31:0] b_mag_q;
  logic [31:0] r_q;      // partial remainder; always < |b| so 32 bits suffice
  logic [31:0] q_q;
  logic        a_neg_q;
  logic        b_neg_q;

  logic        accept;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] r_shift;
  logic [32:0] r_trial;
  logic [31:0] r_next;
  logic [31:0] q_next;

  assign in_ready  = (state_q == StIdle) | flush | ((state_q == StHold) & out_ready);
  assign out_valid = (state_q == StHold) & ~flush;
  assign accept    = in_valid & in_ready;

  assign a_neg = in_sign & in_a[31];
  assign b_neg = in_sign & in_b[31];
  assign a_mag = a_neg ? (~in_a + 32'd1) : in_a;
  assign b_mag = b_neg ? (~in_b + 32'd1) : in_b;

  always_comb begin
    r_shift = {r_q, a_sh_q[31]};
    r_trial = r_shift - {1'b0, b_mag_q};
    r_next  = r_trial[32] ? r_shift[31:0] : r_trial[31:0];
    q_next  = {q_q[30:0], ~r_trial[32]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      a_sh_q   <= 32'd0;
      b_mag_q  <= 32'd0;
      r_q      <= 32'd0;
      q_q      <= 32'd0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      out_quot <= 32'd0;
      out_rem  <= 32'd0;
    end else if (accept) begin
      a_sh_q  <= a_mag;
      b_mag_q <= b_mag;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      r_q     <= 32'd0;
      q_q     <= 32'd0;
      cnt_q   <= 5'd0;
      if (in_b == 32'd0) begin
        state_q  <= StHold;
        out_quot <= 32'hFFFF_FFFF;
        out_rem  <= in_a;
      end else begin
        state_q <= StBusy;
      end
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StBusy: begin
          r_q    <= r_next;
          q_q    <= q_next;
          a_sh_q <= {a_sh_q[30:0], 1'b0};
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= StHold;
            out_quot <= (a_neg_q ^ b_neg_q) ? (~q_next + 32'd1) : q_next;
            out_rem  <= a_neg_q ? (~r_next + 32'd1) : r_next;
          end
        end
        StHold: begin
          if (out_ready) state_q <= StIdle;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_div_iter.sv
// Directed self-checking bench for ysyx_23060203_div_iter.
module tb_ysyx_23060203_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_ready;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_quot;
  logic [31:0] out_rem;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_23060203_div_iter dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_ready (in_ready),
    .in_valid (in_valid),
    .in_sign  (in_sign),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_quot (out_quot),
    .out_rem  (out_rem)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // Issue one op from IDLE, wait for it, capture the result and consume it.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output int lat);
    in_valid = 1'b1; in_sign = s; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    q = out_quot;
    r = out_rem;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_quot !== 32'd0) begin errors++; $display("FAIL reset_quot: got %h expected 0", out_quot); end
    checks++; if (out_rem !== 32'd0) begin errors++; $display("FAIL reset_rem: got %h expected 0", out_rem); end
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r;
    int lat;
    run_op(1'b0, 32'd100, 32'd7, q, r, lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL udiv_latency: got %0d expected 32", lat); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL udiv_quot: got %h expected %h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL udiv_rem: got %h expected %h", r, 32'd2); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL udiv_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_signed();
    logic        s   [4];
    logic [31:0] a   [4];
    logic [31:0] b   [4];
    logic [31:0] eq  [4];
    logic [31:0] er  [4];
    logic [31:0] q, r;
    int lat;
    s[0] = 1; a[0] = 32'hFFFF_FFF9; b[0] = 32'd2;          eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF;
    s[1] = 1; a[1] = 32'd7;         b[1] = 32'hFFFF_FFFE;  eq[1] = 32'hFFFF_FFFD; er[1] = 32'd1;
    s[2] = 1; a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF;  eq[2] = 32'h8000_0000; er[2] = 32'd0;
    s[3] = 0; a[3] = 32'hFFFF_FFFF; b[3] = 32'd1;          eq[3] = 32'hFFFF_FFFF; er[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      run_op(s[i], a[i], b[i], q, r, lat);
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL sdiv_quot[%0d]: got %h expected %h", i, q, eq[i]); end
      checks++; if (r !== er[i]) begin errors++; $display("FAIL sdiv_rem[%0d]: got %h expected %h", i, r, er[i]); end
      checks++; if (lat != 32) begin errors++; $display("FAIL sdiv_latency[%0d]: got %0d expected 32", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    int lat;
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, q, r, lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL dz_signed_latency: got %0d expected 0", lat); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_signed_quot: got %h expected ffffffff", q); end
    checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL dz_signed_rem: got %h expected fffffffb", r); end
    run_op(1'b0, 32'd9, 32'd0, q, r, lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL dz_unsigned_latency: got %0d expected 0", lat); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_unsigned_quot: got %h expected ffffffff", q); end
    checks++; if (r !== 32'd9) begin errors++; $display("FAIL dz_unsigned_rem: got %h expected 9", r); end
  endtask

  task automatic test_flush();
    int lat;
    // Flush in BUSY after 10 steps, replacing the op with 20/3.
    in_valid = 1'b1; in_sign = 1'b0; in_a = 32'd1000; in_b = 32'd3;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd20; in_b = 32'd3;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_busy_in_ready: got %b expected 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL flush_busy_latency: got %0d expected 32", lat); end
    checks++; if (out_quot !== 32'd6) begin errors++; $display("FAIL flush_busy_quot: got %h expected 6", out_quot); end
    checks++; if (out_rem !== 32'd2) begin errors++; $display("FAIL flush_busy_rem: got %h expected 2", out_rem); end
    // Flush in HOLD without a new op: result dropped even with out_ready.
    flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold_priority: got %b expected 0", out_valid); end
    step();
    flush = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_hold_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1; in_sign = 1'b0; in_a = 32'd100; in_b = 32'd7;
    step();
    in_valid = 1'b0;
    wait_valid(lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL bp_latency: got %0d expected 32", lat); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_quot !== 32'd14 || out_rem !== 32'd2) begin
        errors++;
        $display("FAIL bp_stable[%0d]: got v=%b q=%h r=%h expected v=1 q=0000000e r=00000002",
                 i, out_valid, out_quot, out_rem);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; in_sign = 1'b1; in_a = 32'hFFFF_FFF9; in_b = 32'd2;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", in_ready); end
    wait_valid(lat);
    checks++; if (lat != 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
    checks++; if (out_quot !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_quot: got %h expected fffffffd", out_quot); end
    checks++; if (out_rem !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_rem: got %h expected ffffffff", out_rem); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r;
    int lat;
    in_valid = 1'b1; in_sign = 1'b0; in_a = 32'd1000; in_b = 32'd7;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    // Reset wins over a simultaneous flush and new op.
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_a = 32'd77; in_b = 32'd0;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_quot !== 32'd0) begin errors++; $display("FAIL rst_mid_quot: got %h expected 0", out_quot); end
    checks++; if (out_rem !== 32'd0) begin errors++; $display("FAIL rst_mid_rem: got %h expected 0", out_rem); end
    run_op(1'b0, 32'd50, 32'd5, q, r, lat);
    checks++; if (q !== 32'd10) begin errors++; $display("FAIL rst_after_quot: got %h expected a", q); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rst_after_rem: got %h expected 0", r); end
    checks++; if (lat != 32) begin errors++; $display("FAIL rst_after_latency: got %0d expected 32", lat); end
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
